// File: rtl/fp_square_seq_if.sv
// fp_square_seq_if: valid/ready operand and result bundle for the sequential squarer.
// Ports (signals):
//   in_valid, a, round   - operand side, driven by the producer (master)
//   in_ready             - squarer can accept an operand
//   out_valid, z, status - registered result side, driven by the squarer (slave)
//   out_ready            - consumer accepts the result
interface fp_square_seq_if #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [sig_width+ex_width:0]   a;
    logic [2:0]                    round;
    logic                          out_valid;
    logic                          out_ready;
    logic [sig_width+ex_width:0]   z;
    logic [7:0]                    status;

    modport master (
        output in_valid, a, round, out_ready,
        input  in_ready, out_valid, z, status
    );

    modport slave (
        input  in_valid, a, round, out_ready,
        output in_ready, out_valid, z, status
    );
endinterface

// File: rtl/fp_square_seq.sv
// fp_square_seq: multicycle IEEE-754 squarer z = a*a using a radix-2 shift-add significand multiplier.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset
//   enable - global stall; 0 freezes every register and blocks both handshakes
//   bus    - slave side of fp_square_seq_if (operand/round in, z/status out, valid/ready both ways)
module fp_square_seq #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    fp_square_seq_if.slave    bus
);
    localparam int W  = sig_width;
    localparam int E  = ex_width;
    localparam int N  = W + E + 1;
    localparam int CW = $clog2(W + 1);
    localparam logic [E+1:0] BIAS = (E+2)'(2**(E-1) - 1);
    localparam logic [E+1:0] EMAX = (E+2)'(2**E - 1);
    localparam logic [2:0] RTZ = 3'd1, RUP = 3'd2, RDN = 3'd3, RNA = 3'd4;
    localparam logic [1:0] K_NORM = 2'd0, K_ZERO = 2'd1, K_INF = 2'd2, K_NAN = 2'd3;

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W+1:0]  mcand_q, prod_q, prod_d;
    logic [W:0]      mplier_q;
    logic [E-1:0]    ea_q;
    logic [2:0]      rnd_q;
    logic [1:0]      kind_q, kind_in;
    logic            out_valid_q;
    logic [N-1:0]    z_q, z_d;
    logic [7:0]      status_q, status_d;

    logic            norm, g, s, inc, carry, ovf, unf, to_inf;
    logic [W-1:0]    frac_raw, frac_r;
    logic [E+1:0]    e;

    wire [E-1:0] a_exp  = bus.a[N-2:W];
    wire [W-1:0] a_frac = bus.a[W-1:0];

    assign kind_in = &a_exp ? (|a_frac ? K_NAN : K_INF) : (a_exp == '0 ? K_ZERO : K_NORM);

    assign bus.in_ready  = enable && state_q == IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.status    = status_q;

    always_comb begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        // Product of two [1,2) significands lies in [1,4); the top bit selects the normalising shift.
        norm     = prod_q[2*W+1];
        frac_raw = norm ? prod_q[2*W:W+1] : prod_q[2*W-1:W];
        g        = norm ? prod_q[W] : prod_q[W-1];
        s        = norm ? |prod_q[W-1:0] : |prod_q[W-2:0];
        // Result is always positive, so RUP rounds away from zero and RDN truncates.
        inc      = (rnd_q == RTZ || rnd_q == RDN) ? 1'b0 :
                   rnd_q == RUP ? (g | s) :
                   rnd_q == RNA ? g : (g & (s | frac_raw[0]));
        {carry, frac_r} = {1'b0, frac_raw} + (W+1)'(inc);
        e        = {1'b0, ea_q, 1'b0} - BIAS + (E+2)'(norm) + (E+2)'(carry);
        ovf      = !e[E+1] && e >= EMAX;
        unf      = e[E+1] || e == '0;
        to_inf   = !(rnd_q == RTZ || rnd_q == RDN);
        z_d      = kind_q == K_ZERO ? '0 :
                   kind_q == K_INF  ? {1'b0, {E{1'b1}}, {W{1'b0}}} :
                   kind_q == K_NAN  ? {1'b0, {E{1'b1}}, 1'b1, {(W-1){1'b0}}} :
                   ovf ? (to_inf ? {1'b0, {E{1'b1}}, {W{1'b0}}} : {1'b0, {(E-1){1'b1}}, 1'b0, {W{1'b1}}}) :
                   unf ? '0 : {1'b0, e[E-1:0], frac_r};
        status_d = kind_q == K_ZERO ? 8'h01 :
                   kind_q == K_INF  ? 8'h02 :
                   kind_q == K_NAN  ? 8'h04 :
                   ovf ? {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, to_inf, 1'b0} :
                   unf ? 8'h29 : {2'b00, g | s, 5'b0};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            ea_q        <= '0;
            rnd_q       <= '0;
            kind_q      <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            status_q    <= '0;
        end else if (enable) begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    cnt_q    <= '0;
                    prod_q   <= '0;
                    mcand_q  <= {{(W+1){1'b0}}, 1'b1, a_frac};
                    mplier_q <= {1'b1, a_frac};
                    ea_q     <= a_exp;
                    rnd_q    <= bus.round;
                    kind_q   <= kind_in;
                    state_q  <= kind_in == K_NORM ? MUL : RND;
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W))
                        state_q <= RND;
                end
                RND: begin
                    z_q         <= z_d;
                    status_q    <= status_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_square_seq.sv
// tb_fp_square_seq: directed-vector bench for fp_square_seq with hand-computed results.
// Ports: none (drives clk/resetn/enable and the master side of fp_square_seq_if).
module tb_fp_square_seq;
    logic clk = 1'b0;
    logic resetn;
    logic enable;
    int   tests = 0;
    int   fails = 0;

    fp_square_seq_if #(.sig_width(23), .ex_width(8)) bus ();

    fp_square_seq #(.sig_width(23), .ex_width(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operand, count edges until out_valid, optionally stalling for 5 edges after st edges.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [2:0] rm,
                          input logic [31:0] ez, input logic [7:0] es, input int elat, input int st);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.round    = rm;
        #1 check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEADBEEF;
        bus.round    = 3'd3;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (lat == st) enable = 1'b0;
            if (lat == st + 5) enable = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        enable = 1'b1;
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_z"}, bus.z, ez);
        check({tag, "_st"}, 32'(bus.status), 32'(es));
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ovclr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy2"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        resetn        = 1'b0;
        enable        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.round     = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_z", bus.z, 32'd0);
        check("rst_st", 32'(bus.status), 32'd0);
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        run_op("one",     32'h3F800000, 3'd0, 32'h3F800000, 8'h00, 26, 0); drain("one");
        run_op("p15",     32'h3FC00000, 3'd0, 32'h40100000, 8'h00, 26, 0); drain("p15");
        run_op("m3",      32'hC0400000, 3'd0, 32'h41100000, 8'h00, 26, 0); drain("m3");
        run_op("ulp_rne", 32'h3F800001, 3'd0, 32'h3F800002, 8'h20, 26, 0); drain("ulp_rne");
        run_op("ulp_rup", 32'h3F800001, 3'd2, 32'h3F800003, 8'h20, 26, 0); drain("ulp_rup");
        run_op("ovf_rne", 32'h71800000, 3'd0, 32'h7F800000, 8'h32, 26, 0); drain("ovf_rne");
        run_op("ovf_rtz", 32'h71800000, 3'd1, 32'h7F7FFFFF, 8'h30, 26, 0); drain("ovf_rtz");
        run_op("unf",     32'h1C800000, 3'd0, 32'h00000000, 8'h29, 26, 0); drain("unf");
        run_op("nan",     32'h7FC00001, 3'd0, 32'h7FC00000, 8'h04,  2, 0); drain("nan");
        run_op("ninf",    32'hFF800000, 3'd0, 32'h7F800000, 8'h02,  2, 0); drain("ninf");
        run_op("nzero",   32'h80000000, 3'd0, 32'h00000000, 8'h01,  2, 0); drain("nzero");
        run_op("denorm",  32'h00000001, 3'd0, 32'h00000000, 8'h01,  2, 0); drain("denorm");

        bus.out_ready = 1'b0;
        run_op("bp", 32'h40400000, 3'd0, 32'h41100000, 8'h00, 26, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_ov", 32'(bus.out_valid), 32'd1);
            check("bp_z", bus.z, 32'h41100000);
            check("bp_st", 32'(bus.status), 32'h00);
            check("bp_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        drain("bp");

        run_op("stall", 32'h3FC00000, 3'd0, 32'h40100000, 8'h00, 31, 5); drain("stall");

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h40000000;
        bus.round    = 3'd0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mrst_ov", 32'(bus.out_valid), 32'd0);
        check("mrst_z", bus.z, 32'd0);
        check("mrst_st", 32'(bus.status), 32'd0);
        check("mrst_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post", 32'h40000000, 3'd0, 32'h40800000, 8'h00, 26, 0); drain("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
